// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/execute memory arbiter: FSM state
// encodings and the RAM access size code used for instruction fetches.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_IF = 2'b01,
        ST_BUSY_EX = 2'b10
    } arbState_e;

    // Size code for a full 32-bit word access
    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog for the memory arbiter. Counts cycles spent waiting
// for a RAM ack and flags the cycle in which the wait limit is reached.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             atLast;

    assign atLast    = run_i && (count_q == LAST_CNT);
    assign expired_o = atLast;

    // Restart on every new grant, otherwise count busy cycles up to the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && !atLast) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one RAM port between instruction fetch (IF)
// and the execute stage (EX). EX normally wins, but an IF that lost a
// contended arbitration wins the next one. Optional busy timeout is enabled
// by defining MEM_ARB_TIMEOUT_EN; without it the arbiter waits for ack forever.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        ex_req_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [2:0]  ex_size_i,
    output logic        ex_gnt_o,
    output logic        ex_rvalid_o,
    output logic [31:0] ex_rdata_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [2:0]  ram_size_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i,

    output logic        hold_flag_o,
    output logic        err_o
);

    arbState_e   state_q;
    arbState_e   state_d;
    logic        starve_q;
    logic        starve_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  size_q;

    logic        ifRvalid_q;
    logic        exRvalid_q;
    logic [31:0] ifRdata_q;
    logic [31:0] exRdata_q;

    logic        isIdle;
    logic        busy;
    logic        ifGrant;
    logic        exGrant;
    logic        timeoutHit;
    logic        done;

    assign isIdle = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_EX);

    // Grants are masked by rst_n so every output reads 0 while reset is held
    assign exGrant = rst_n && isIdle && ex_req_i && (!if_req_i || !starve_q);
    assign ifGrant = rst_n && isIdle && if_req_i && (!ex_req_i || starve_q);

    // An ack always wins over a timeout landing in the same cycle
    assign done = busy && (ram_ack_i || timeoutHit);

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (ifGrant || exGrant),
        .run_i     (busy),
        .expired_o (timeoutHit)
    );

    // Abort pulse lines up with the owner's rvalid of the abandoned access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= busy && timeoutHit && !ram_ack_i;
        end
    end

    assign err_o = err_q;
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = ^TIMEOUT_CYC;
    assign timeoutHit       = 1'b0;
    assign err_o            = 1'b0;
`endif

    // FSM state and starve flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state: only IDLE accepts work, BUSY leaves on ack or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (exGrant) begin
                    state_d = ST_BUSY_EX;
                end else if (ifGrant) begin
                    state_d = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_EX: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Remember an IF that lost to EX so it wins the next contended round
    always_comb begin
        starve_d = starve_q;
        if (ifGrant) begin
            starve_d = 1'b0;
        end else if (isIdle && if_req_i && ex_req_i) begin
            starve_d = 1'b1;
        end
    end

    // Capture the winning request so the RAM side stays stable until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
        end else if (exGrant) begin
            addr_q  <= ex_addr_i;
            wdata_q <= ex_wdata_i;
            we_q    <= ex_we_i;
            size_q  <= ex_size_i;
        end else if (ifGrant) begin
            addr_q  <= if_addr_i;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_WORD;
        end
    end

    // Completion pulses one cycle after ack; read data held until next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifRvalid_q <= 1'b0;
            exRvalid_q <= 1'b0;
            ifRdata_q  <= '0;
            exRdata_q  <= '0;
        end else begin
            ifRvalid_q <= done && (state_q == ST_BUSY_IF);
            exRvalid_q <= done && (state_q == ST_BUSY_EX);
            if (done && (state_q == ST_BUSY_IF)) begin
                ifRdata_q <= ram_ack_i ? ram_rdata_i : '0;
            end
            if (done && (state_q == ST_BUSY_EX)) begin
                exRdata_q <= (ram_ack_i && !we_q) ? ram_rdata_i : '0;
            end
        end
    end

    // Output decode: grant pulses in IDLE, RAM port driven only while busy
    always_comb begin
        if_gnt_o    = ifGrant;
        ex_gnt_o    = exGrant;
        ram_req_o   = busy;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_size_o  = '0;
        if (busy) begin
            ram_we_o    = we_q;
            ram_addr_o  = addr_q;
            ram_wdata_o = wdata_q;
            ram_size_o  = size_q;
        end
    end

    assign if_rvalid_o = ifRvalid_q;
    assign if_rdata_o  = ifRdata_q;
    assign ex_rvalid_o = exRvalid_q;
    assign ex_rdata_o  = exRdata_q;
    assign hold_flag_o = rst_n && ex_req_i && !exRvalid_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: max cycles in a busy state before abort; only used under MEM_ARB_TIMEOUT_EN.
REQ-002 clk  input  1  core clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 if_req_i  input  1 / if_addr_i  input  32: fetch read request and its address.
REQ-005 if_gnt_o  output  1 / if_rvalid_o  output  1 / if_rdata_o  output  32: fetch accept pulse, completion pulse, read data.
REQ-006 ex_req_i  input  1 / ex_we_i  input  1 / ex_addr_i  input  32 / ex_wdata_i  input  32 / ex_size_i  input  3: execute-stage load/store request, write flag, address, store data, size code.
REQ-007 ex_gnt_o  output  1 / ex_rvalid_o  output  1 / ex_rdata_o  output  32: data accept pulse, completion pulse, load data.
REQ-008 ram_req_o  output  1 / ram_we_o  output  1 / ram_addr_o  output  32 / ram_wdata_o  output  32 / ram_size_o  output  3: single shared RAM port.
REQ-009 ram_ack_i  input  1 / ram_rdata_i  input  32: RAM completion and read data, valid in the ack cycle.
REQ-010 hold_flag_o  output  1: pipeline stall to control.
REQ-011 err_o  output  1: timeout-abort pulse.

Function
REQ-012 FSM states IDLE, BUSY_IF, BUSY_EX; only IDLE accepts requests.
REQ-013 In IDLE, a single requester is granted: combinational gnt pulse in that cycle, request fields latched, next state BUSY_<owner>.
REQ-014 Both requesting in IDLE: EX wins, unless IF lost the previous contended arbitration (starve flag set), then IF wins and the flag clears.
REQ-015 Starve flag sets when IF is refused because of EX; clears on any IF grant.
REQ-016 In BUSY_*: ram_req_o=1 and ram_* driven from latched fields, stable until ram_ack_i.
REQ-017 ram_ack_i in BUSY_*: next state IDLE; owner rvalid pulses one cycle later for exactly one cycle with captured ram_rdata_i.
REQ-018 EX writes also pulse ex_rvalid_o on completion; ex_rdata_o=0 for writes.
REQ-019 Latency with zero-wait RAM: accept cycle T, ram_req_o/ack T+1, rvalid T+2; a new grant is allowed in T+2.
REQ-020 IF fetch: ram_we_o=0, ram_size_o=3'b010 (word), ram_wdata_o=0.
REQ-021 hold_flag_o=1 when ex_req_i=1 and ex_rvalid_o=0 in that cycle; otherwise 0.
REQ-022 Requests deasserted after grant do not cancel the transaction.
REQ-023 ram_ack_i in IDLE is ignored.
REQ-024 rdata outputs hold their last value between rvalid pulses.

Reset
REQ-025 On rst_n low: state IDLE, starve flag 0, every output 0, latched fields 0, effective immediately.
REQ-026 Reset mid-transaction drops ram_req_o at once; no rvalid is produced for the aborted access.

Configuration
REQ-027 Macro MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY_*, clears on entry, and on reaching TIMEOUT_CYC without ack the transaction is abandoned (next state IDLE), owner rvalid pulses with rdata 0, and err_o pulses with it.
REQ-028 Macro undefined: BUSY_* waits indefinitely for ack, no counter is instantiated, and err_o is tied to 0.

Structure
REQ-029 FSM state encodings and the word size code belong in the shared common defines file.
REQ-030 Timeout counter is a sub-module, mem_arb_timer, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-031 IF only, addr 0x100, ack next cycle with rdata 0x00000013 -> if_gnt_o at T, ram_req_o at T+1, if_rvalid_o and if_rdata_o=0x00000013 at T+2.
REQ-032 IF and EX request together in IDLE (EX load 0x2000) -> ex_gnt_o first; on next IDLE with both still requesting, if_gnt_o wins; hold_flag_o=1 until ex_rvalid_o.
REQ-033 EX store of 0xCAFEF00D to 0x3000, size 3'b010, ack delayed 5 cycles -> ram_* stable for all 5 cycles, ram_we_o=1, ex_rvalid_o 1 cycle after ack, ex_rdata_o=0.
REQ-034 rst_n pulled low during BUSY_EX, then late ram_ack_i after release -> all outputs 0, no rvalid, next IF request is granted normally.
REQ-035 MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ack -> abort after 4 busy cycles, err_o and owner rvalid pulse together, rdata=0; undefined: ram_req_o held for 100 cycles and err_o stays 0.
